// File: rtl/hram_ie_if_unit_if.sv
// CPU-side bus bundle for the $FF00-page internal-state responder.
// The master is the CPU core and the slave is hram_ie_if_unit.
interface hram_ie_if_unit_if;
    logic        mcyc_t1;
    logic [15:0] adr;
    logic        rd;
    logic        wr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        sel;

    modport master (
        output mcyc_t1, adr, rd, wr, wdata,
        input  rdata, sel
    );

    modport slave (
        input  mcyc_t1, adr, rd, wr, wdata,
        output rdata, sel
    );
endinterface

// File: rtl/hram_ie_if_unit.sv
// HRAM ($FF80-$FFFE), IF ($FF0F) and IE ($FFFF) storage with registered read data
// and the pending-interrupt request back to the CPU core.
//
// tphase  | meaning (phase completed at the last edge)
// TP_T4   | T4 done, current cycle is T1 (reset value)
// TP_T1   | T1 done, access latched, current cycle is T2
// TP_T2   | T2 done, current cycle is T3, write commits at the next edge
// TP_T3   | T3 done, current cycle is T4, read data drops at the next edge
module hram_ie_if_unit #(
    parameter logic [15:0] HRAM_BASE = 16'hff80,
    parameter logic [15:0] IF_ADR    = 16'hff0f,
    parameter logic [15:0] IE_ADR    = 16'hffff
) (
    input  logic                    clk,
    input  logic                    nreset,
    hram_ie_if_unit_if.slave        bus,
    input  logic [4:0]              irq_set,
    input  logic [4:0]              irq_ack,
    output logic                    irq_pending
);

    typedef enum logic [1:0] {
        TP_T4 = 2'd0,
        TP_T1 = 2'd1,
        TP_T2 = 2'd2,
        TP_T3 = 2'd3
    } tphase_t;

    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_HRAM = 2'd1,
        ACC_IF   = 2'd2,
        ACC_IE   = 2'd3
    } acc_t;

    tphase_t     tphase_q, tphase_d;
    logic        sel_q, sel_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [4:0]  if_q, if_d;
    logic [7:0]  ie_q, ie_d;
    logic        wr_pend_q, wr_pend_d;
    acc_t        wr_kind_q, wr_kind_d;
    logic [6:0]  wr_idx_q, wr_idx_d;

    logic [7:0]  hram_q [127];

    acc_t        hit_kind;
    logic [7:0]  rd_val;
    logic        commit;
    logic        hram_we;

    always_comb begin
        hit_kind = ACC_NONE;
        if (bus.adr == IE_ADR)
            hit_kind = ACC_IE;
        else if (bus.adr == IF_ADR)
            hit_kind = ACC_IF;
        else if ((bus.adr >= HRAM_BASE) && (bus.adr <= 16'hfffe))
            hit_kind = ACC_HRAM;
    end

    always_comb begin
        rd_val = 8'h00;
        case (hit_kind)
            ACC_IE:   rd_val = ie_q;
            ACC_IF:   rd_val = {3'b111, if_q};
            ACC_HRAM: rd_val = hram_q[bus.adr[6:0]];
            default:  rd_val = 8'h00;
        endcase
    end

    always_comb begin
        tphase_d  = bus.mcyc_t1 ? TP_T1 : tphase_t'(tphase_q + 2'd1);
        sel_d     = sel_q;
        rdata_d   = rdata_q;
        wr_pend_d = wr_pend_q;
        wr_kind_d = wr_kind_q;
        wr_idx_d  = wr_idx_q;

        // The write latched at T1 lands on the T3->T4 edge, ahead of the next T1 latch.
        commit = wr_pend_q && (tphase_q == TP_T2);
        if (commit)
            wr_pend_d = 1'b0;

        if (tphase_q == TP_T3) begin
            sel_d   = 1'b0;
            rdata_d = 8'h00;
        end

        if (bus.mcyc_t1) begin
            sel_d     = 1'b0;
            rdata_d   = 8'h00;
            wr_pend_d = bus.wr && !bus.rd && (hit_kind != ACC_NONE);
            wr_kind_d = hit_kind;
            wr_idx_d  = bus.adr[6:0];
            if (bus.rd && (hit_kind != ACC_NONE)) begin
                sel_d   = 1'b1;
                rdata_d = rd_val;
            end
        end
    end

    always_comb begin
        ie_d = ie_q;
        if (commit && (wr_kind_q == ACC_IE))
            ie_d = bus.wdata;

        // CPU write wins over peripheral set, which wins over dispatch ack.
        if_d = (if_q & ~irq_ack) | irq_set;
        if (commit && (wr_kind_q == ACC_IF))
            if_d = bus.wdata[4:0];

        hram_we = commit && (wr_kind_q == ACC_HRAM) && (wr_idx_q != 7'h7f);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            tphase_q  <= TP_T4;
            sel_q     <= 1'b0;
            rdata_q   <= 8'h00;
            if_q      <= 5'h00;
            ie_q      <= 8'h00;
            wr_pend_q <= 1'b0;
            wr_kind_q <= ACC_NONE;
            wr_idx_q  <= 7'h00;
        end else begin
            tphase_q  <= tphase_d;
            sel_q     <= sel_d;
            rdata_q   <= rdata_d;
            if_q      <= if_d;
            ie_q      <= ie_d;
            wr_pend_q <= wr_pend_d;
            wr_kind_q <= wr_kind_d;
            wr_idx_q  <= wr_idx_d;
        end
    end

    // HRAM is deliberately left unreset; reset still blocks writes via wr_pend_q.
    always_ff @(posedge clk) begin
        if (hram_we)
            hram_q[wr_idx_q] <= bus.wdata;
    end

    assign bus.sel     = sel_q;
    assign bus.rdata   = rdata_q;
    assign irq_pending = |(ie_q[4:0] & if_q);

endmodule

// File: tb/tb_hram_ie_if_unit.sv
// Directed bench for hram_ie_if_unit: drives CPU M-cycles and interrupt pulses,
// checking read data, sel timing, IF/IE behaviour and reset abort of writes.
module tb_hram_ie_if_unit;

    logic       clk;
    logic       nreset;
    logic [4:0] irq_set;
    logic [4:0] irq_ack;
    logic       irq_pending;

    hram_ie_if_unit_if bus ();

    hram_ie_if_unit dut (
        .clk         (clk),
        .nreset      (nreset),
        .bus         (bus.slave),
        .irq_set     (irq_set),
        .irq_ack     (irq_ack),
        .irq_pending (irq_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [3:0] cap_sel;
    logic [7:0] cap_rd [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One M-cycle; samples are taken 1ns after each edge (T2, T3, T4, next T1).
    task automatic mcycle(input logic [15:0] a, input logic r, input logic w,
                          input logic [7:0] d, input logic [4:0] set_t3);
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            bus.mcyc_t1 = (t == 0);
            bus.adr     = a;
            bus.rd      = r;
            bus.wr      = w;
            bus.wdata   = d;
            irq_set     = (t == 2) ? set_t3 : 5'h00;
            @(posedge clk);
            #1;
            cap_sel[t] = bus.sel;
            cap_rd[t]  = bus.rdata;
        end
        @(negedge clk);
        irq_set = 5'h00;
        bus.rd  = 1'b0;
        bus.wr  = 1'b0;
    endtask

    task automatic wr_cyc(input string tag, input logic [15:0] a, input logic [7:0] d,
                          input logic [4:0] set_t3);
        mcycle(a, 1'b0, 1'b1, d, set_t3);
        chk({tag, "_sel"}, {28'h0, cap_sel}, 32'h0);
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] a, input logic [7:0] exp);
        mcycle(a, 1'b1, 1'b0, 8'h00, 5'h00);
        chk({tag, "_sel"}, {28'h0, cap_sel}, 32'h7);
        chk({tag, "_data"}, {cap_rd[3], cap_rd[2], cap_rd[1], cap_rd[0]}, {8'h00, exp, exp, exp});
    endtask

    task automatic rd_miss(input string tag, input logic [15:0] a);
        mcycle(a, 1'b1, 1'b0, 8'h00, 5'h00);
        chk({tag, "_sel"}, {28'h0, cap_sel}, 32'h0);
        chk({tag, "_data"}, {cap_rd[3], cap_rd[2], cap_rd[1], cap_rd[0]}, 32'h0);
    endtask

    task automatic pulse(input logic [4:0] s, input logic [4:0] k);
        @(negedge clk);
        irq_set = s;
        irq_ack = k;
        @(negedge clk);
        irq_set = 5'h00;
        irq_ack = 5'h00;
    endtask

    initial begin
        nreset      = 1'b0;
        irq_set     = 5'h00;
        irq_ack     = 5'h00;
        bus.mcyc_t1 = 1'b0;
        bus.adr     = 16'h0000;
        bus.rd      = 1'b0;
        bus.wr      = 1'b0;
        bus.wdata   = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_sel", {31'h0, bus.sel}, 32'h0);
        chk("rst_rdata", {24'h0, bus.rdata}, 32'h0);
        chk("rst_pend", {31'h0, irq_pending}, 32'h0);
        @(negedge clk);
        nreset = 1'b1;
        repeat (2) @(negedge clk);

        // IE enable, then a peripheral set pulse on bit 2
        wr_cyc("ie_wr", 16'hffff, 8'h1f, 5'h00);
        rd_chk("ie_rd", 16'hffff, 8'h1f);
        @(negedge clk);
        irq_set = 5'b00100;
        #1;
        chk("pend_before", {31'h0, irq_pending}, 32'h0);
        @(posedge clk);
        #1;
        chk("pend_after", {31'h0, irq_pending}, 32'h1);
        @(negedge clk);
        irq_set = 5'h00;
        rd_chk("if_rd_e4", 16'hff0f, 8'he4);

        // HRAM at both ends of the range, plus a read-after-write
        wr_cyc("hram_lo_wr", 16'hff80, 8'h5a, 5'h00);
        wr_cyc("hram_hi_wr", 16'hfffe, 8'ha5, 5'h00);
        rd_chk("hram_lo_rd", 16'hff80, 8'h5a);
        rd_chk("hram_hi_rd", 16'hfffe, 8'ha5);

        // Addresses just outside the decoded regions
        rd_miss("miss_ff7f", 16'hff7f);
        rd_miss("miss_ff10", 16'hff10);

        // rd and wr together behave as a read with no write
        wr_cyc("hram81_wr", 16'hff81, 8'h22, 5'h00);
        mcycle(16'hff81, 1'b1, 1'b1, 8'h77, 5'h00);
        chk("rdwr_sel", {28'h0, cap_sel}, 32'h7);
        chk("rdwr_data", {cap_rd[3], cap_rd[2], cap_rd[1], cap_rd[0]}, 32'h00222222);
        rd_chk("rdwr_kept", 16'hff81, 8'h22);

        // Set and ack on the same bit in the same cycle leave it set
        wr_cyc("if_wr_01", 16'hff0f, 8'h01, 5'h00);
        pulse(5'b00001, 5'b00001);
        rd_chk("if_setack", 16'hff0f, 8'he1);
        chk("pend_setack", {31'h0, irq_pending}, 32'h1);
        pulse(5'b00000, 5'b00001);
        rd_chk("if_ack", 16'hff0f, 8'he0);
        chk("pend_ack", {31'h0, irq_pending}, 32'h0);

        // CPU write to IF beats a concurrent set
        wr_cyc("if_wr_ff", 16'hff0f, 8'hff, 5'b00010);
        rd_chk("if_rd_ff", 16'hff0f, 8'hff);
        wr_cyc("if_wr_00", 16'hff0f, 8'h00, 5'h00);
        rd_chk("if_rd_e0", 16'hff0f, 8'he0);

        // Reset in T3 of a write aborts it
        wr_cyc("hram90_pre", 16'hff90, 8'h11, 5'h00);
        wr_cyc("ie_wr_ff", 16'hffff, 8'hff, 5'h00);
        wr_cyc("if_wr_1f", 16'hff0f, 8'h1f, 5'h00);
        chk("pend_pre_rst", {31'h0, irq_pending}, 32'h1);
        @(negedge clk);
        bus.mcyc_t1 = 1'b1;
        bus.adr     = 16'hff90;
        bus.wr      = 1'b1;
        bus.wdata   = 8'h33;
        @(negedge clk);
        bus.mcyc_t1 = 1'b0;
        @(negedge clk);
        nreset = 1'b0;
        #1;
        chk("abort_sel", {31'h0, bus.sel}, 32'h0);
        chk("abort_pend", {31'h0, irq_pending}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        bus.wr = 1'b0;
        nreset = 1'b1;
        @(negedge clk);
        rd_chk("abort_hram", 16'hff90, 8'h11);
        rd_chk("abort_if", 16'hff0f, 8'he0);
        rd_chk("abort_ie", 16'hffff, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/hram_ie_if_unit.md
Name: hram_ie_if_unit

Overview:
- Responds to CPU bus cycles in the $FF00 page that hold CPU-internal state:
  - HRAM, $FF80-$FFFE (127 bytes)
  - interrupt flag register IF, $FF0F
  - interrupt enable register IE, $FFFF
- Sits directly downstream of the CPU core. It is the memory that supplies the data byte an "LD A, ($FF00+n)" read returns in the instruction's third M-cycle.
- Also raises the pending-interrupt request back to the CPU.

Parameters:
- HRAM_BASE, 16'hff80, first HRAM address; HRAM runs from HRAM_BASE to $FFFE inclusive.
- IF_ADR, 16'hff0f, address of IF.
- IE_ADR, 16'hffff, address of IE.

Ports:
- clk  in  1  CPU clock; one T-cycle per rising edge.
- nreset  in  1  asynchronous, active-low reset.
- mcyc_t1  in  1  high during T1 of every M-cycle; defines the T-phase.
- adr  in  16  CPU address; stable from T1 to T4 of an M-cycle.
- rd  in  1  CPU read strobe; sampled at the end of T1.
- wr  in  1  CPU write strobe; sampled at the end of T1.
- wdata  in  8  CPU write data; valid at T3.
- rdata  out  8  read data to the CPU.
- sel  out  1  high when this unit drives rdata, so the upstream bus mux picks it.
- irq_set  in  5  one-cycle pulses from peripherals; bit i sets IF[i].
- irq_ack  in  5  one-hot pulse from the CPU on interrupt dispatch; clears IF[i].
- irq_pending  out  1  OR over bits 4:0 of (IE & IF).

Behaviour:
- T-phase counter tphase (2 bits):
  - Loaded to 1 on mcyc_t1, otherwise increments 1->2->3->0 (0 = T4).
  - Reset value is 0.
  - If mcyc_t1 arrives in any phase, the counter resynchronises to T1 with no error.
- Address decode at the end of T1 (latched; adr changes later in the cycle are ignored):
  - hit = HRAM range, IF_ADR or IE_ADR.
  - A latched access holds for the rest of the M-cycle.
  - rd and wr both high: treat as a read; no write occurs.
- Read:
  - sel and rdata become valid from T2 through T4 (registered at the T1->T2 edge).
  - Then sel = 0 and rdata = 8'h00.
  - IF reads return {3'b111, IF[4:0]}.
  - IE reads return all 8 stored bits.
  - HRAM reads return the stored byte.
  - A non-hit read leaves sel = 0.
- Write:
  - Committed at the T3->T4 edge using wdata.
  - An IF write stores only bits 4:0.
  - An IE write stores all 8 bits.
  - An HRAM write stores one byte.
  - sel stays 0 during writes.
- IF update priority for each bit, per edge:
  - CPU write to IF beats irq_set, which beats irq_ack.
  - A set and an ack for the same bit in the same cycle leave the bit set.
- irq_pending is combinational from the registered IE and IF; it reflects an update in the cycle after it.
- Reset:
  - IF = 5'h00, IE = 8'h00, sel = 0, rdata = 8'h00, tphase = 0.
  - HRAM contents are not reset and are undefined after power-up.
  - Asserting reset mid-M-cycle aborts any pending write; nothing is committed.
- Read-after-write:
  - A read in the M-cycle after a write to the same address returns the new value.
  - There is no internal bypass; the commit at the T3->T4 edge precedes the next T1 latch.
- Implementation:
  - HRAM is a 127x8 register array indexed by adr[6:0]; index 7'h7f is never addressed because $FFFF decodes to IE.
  - No combinational path from adr to rdata.

Test Plan:
- Reset, then IE write 8'h1f, then irq_set = 5'b00100 pulse -> IF reads 8'he4, irq_pending = 1 one cycle after the pulse.
- HRAM write $FF80 <- 8'h5a, $FFFE <- 8'ha5, then reads of both -> rdata 8'h5a and 8'ha5 during T2-T4, sel high exactly those three cycles.
- Read of $FF7F and $FF10 -> sel = 0 the whole M-cycle, rdata = 8'h00.
- IF = 5'b00001, then irq_ack = 5'b00001 and irq_set = 5'b00001 in the same cycle -> IF[0] stays 1; a later ack alone -> IF reads 8'he0, irq_pending = 0.
- IF write 8'hff at T3->T4 while irq_set = 5'b00010 -> IF = 5'h1f and reads back 8'hff; a following IF write 8'h00 -> reads 8'he0.
- Assert nreset during T3 of a write of 8'h33 to $FF90 -> $FF90 keeps its prior value (pre-loaded 8'h11); IF/IE = 0 and sel = 0 immediately.
